stat_sweeper: RTL and testbench

Read-side master for the per-flow packet statistics block: on a start command it walks a range of flow numbers, issues one read strobe per flow on the statistics read port, and captures each returned counter. Each result is forwarded as a {flow, count} beat on a valid/ready output stream. Sweep-wide aggregates (total, maximum and its flow, timeout count) are also kept. It sits between the statistics store and the host/export logic that drains counters.

---
 rtl/stat_sweeper_if.sv | 26 ++
 rtl/stat_sweeper.sv | 123 ++++++++++++
 tb/tb_stat_sweeper.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stat_sweeper_if.sv
// Read port towards the statistics store plus the {flow, count} result stream.
interface stat_sweeper_if #(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned D_WIDTH = 32
);
  logic               rd_stb;
  logic [A_WIDTH-1:0] rd_flow_num;
  logic [D_WIDTH-1:0] rd_data;
  logic               rd_data_val;

  logic               out_valid;
  logic               out_ready;
  logic [A_WIDTH-1:0] out_flow;
  logic [D_WIDTH-1:0] out_data;
  logic               out_last;

  modport master (
    output rd_stb, rd_flow_num, out_valid, out_flow, out_data, out_last,
    input  rd_data, rd_data_val, out_ready
  );

  modport slave (
    input  rd_stb, rd_flow_num, out_valid, out_flow, out_data, out_last,
    output rd_data, rd_data_val, out_ready
  );
endinterface

// File: rtl/stat_sweeper.sv
// Walks a flow range, reads one counter per flow, streams {flow, count} beats
// and keeps sweep-wide total / max / timeout aggregates.
module stat_sweeper #(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [A_WIDTH-1:0]         first_flow_i,
  input  logic [A_WIDTH-1:0]         last_flow_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [D_WIDTH+A_WIDTH-1:0] total_o,
  output logic [D_WIDTH-1:0]         max_o,
  output logic [A_WIDTH-1:0]         max_flow_o,
  output logic [A_WIDTH:0]           timeout_cnt_o,
  stat_sweeper_if.master             bus
);

  localparam int unsigned TW = D_WIDTH + A_WIDTH;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] cur_flow_q;
  logic [A_WIDTH-1:0] last_q;
  logic [CW-1:0]      wait_q;
  logic [D_WIDTH-1:0] data_q;

  logic               is_last;
  logic               capture;
  logic               timed_out;
  logic [D_WIDTH-1:0] cap_data;

  assign is_last = (cur_flow_q == last_q);

  always_comb begin
    state_d         = state_q;
    capture         = 1'b0;
    timed_out       = 1'b0;
    cap_data        = '0;
    busy_o          = (state_q != S_IDLE);
    done_o          = (state_q == S_DONE);
    bus.rd_stb      = (state_q == S_REQ);
    bus.rd_flow_num = cur_flow_q;
    bus.out_valid   = (state_q == S_PUSH);
    bus.out_flow    = cur_flow_q;
    bus.out_data    = data_q;
    bus.out_last    = (state_q == S_PUSH) && is_last;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        // A response on the expiry cycle still counts as a real read.
        if (bus.rd_data_val) begin
          capture  = 1'b1;
          cap_data = bus.rd_data;
          state_d  = S_PUSH;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          capture   = 1'b1;
          timed_out = 1'b1;
          state_d   = S_PUSH;
        end
      end
      S_PUSH: if (bus.out_ready) state_d = is_last ? S_DONE : S_REQ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      cur_flow_q    <= '0;
      last_q        <= '0;
      wait_q        <= '0;
      data_q        <= '0;
      total_o       <= '0;
      max_o         <= '0;
      max_flow_o    <= '0;
      timeout_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cur_flow_q    <= first_flow_i;
            last_q        <= last_flow_i;
            total_o       <= '0;
            max_o         <= '0;
            max_flow_o    <= '0;
            timeout_cnt_o <= '0;
          end
        end
        S_REQ: wait_q <= '0;
        S_WAIT: begin
          wait_q <= wait_q + CW'(1);
          if (capture) begin
            data_q  <= cap_data;
            total_o <= total_o + TW'(cap_data);
            if (cap_data > max_o) begin
              max_o      <= cap_data;
              max_flow_o <= cur_flow_q;
            end
            if (timed_out) timeout_cnt_o <= timeout_cnt_o + (A_WIDTH + 1)'(1);
          end
        end
        S_PUSH: if (bus.out_ready && !is_last) cur_flow_q <= cur_flow_q + A_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stat_sweeper.sv
// Table-driven sweeps with a responder model and a beat scoreboard queue.
module tb_stat_sweeper;

  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    int              first;
    int              last;
    logic [3:0][31:0] d;
    logic [3:0][7:0]  dly;     // response delay after strobe; 0 = never answers
    int              ready_low;
    bit              poke;     // mid-sweep start pulse and stray valids in PUSH
    longint          exp_total;
    longint          exp_max;
    int              exp_mf;
    int              exp_to;
    int              exp_beats;
    int              exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [AW-1:0]    first_flow, last_flow;
  logic             busy, done;
  logic [DW+AW-1:0] total;
  logic [DW-1:0]    max_v;
  logic [AW-1:0]    max_flow;
  logic [AW:0]      to_cnt;

  stat_sweeper_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  stat_sweeper #(.A_WIDTH(AW), .D_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .start_i       (start),
    .first_flow_i  (first_flow),
    .last_flow_i   (last_flow),
    .busy_o        (busy),
    .done_o        (done),
    .total_o       (total),
    .max_o         (max_v),
    .max_flow_o    (max_flow),
    .timeout_cnt_o (to_cnt),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t        tbl[7];
  vec_t        cur;
  logic [42:0] q[$];
  logic [AW-1:0] exp_flow, exp_last;
  int  exp_idx, nstb, nbeats, ndone;
  int  cyc = 0, start_cyc, first_stb_cyc, last_hs_cyc, done_cyc;
  int  ready_low_left;
  bit  poke, start_req, pend;
  int  pend_cnt;
  logic [31:0] pend_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(int first, int last, int d0, int d1, int d2, int d3,
                              int y0, int y1, int y2, int y3, int rlow, bit pk,
                              longint tot, longint mx, int mf, int to, int beats, int cycs);
    vec_t v;
    v.first = first; v.last = last;
    v.d[0] = 32'(d0); v.d[1] = 32'(d1); v.d[2] = 32'(d2); v.d[3] = 32'(d3);
    v.dly[0] = 8'(y0); v.dly[1] = 8'(y1); v.dly[2] = 8'(y2); v.dly[3] = 8'(y3);
    v.ready_low = rlow; v.poke = pk;
    v.exp_total = tot; v.exp_max = mx; v.exp_mf = mf; v.exp_to = to;
    v.exp_beats = beats; v.exp_cycles = cycs;
    return v;
  endfunction

  // One clock: sample at the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    logic [7:0]  dly;
    logic [31:0] dat;
    @(negedge clk);
    cyc++;
    bus.rd_data_val = 1'b0;
    bus.rd_data     = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.rd_data_val = 1'b1;
        bus.rd_data     = pend_data;
        pend            = 1'b0;
      end
    end
    if (bus.rd_stb) begin
      if (nstb == 0) begin
        first_stb_cyc = cyc;
        chk("busy_at_first_stb", 64'(busy), 64'd1);
        chk("start_to_stb", 64'(cyc), 64'(start_cyc + 1));
      end else begin
        chk("stb_after_handshake", 64'(cyc), 64'(last_hs_cyc + 1));
      end
      chk("stb_flow", 64'(bus.rd_flow_num), 64'(exp_flow));
      dly = (exp_idx < 4) ? cur.dly[exp_idx] : 8'd1;
      dat = (exp_idx < 4) ? cur.d[exp_idx] : 32'd0;
      if (dly != 0) begin
        pend = 1'b1; pend_cnt = int'(dly); pend_data = dat;
      end
      q.push_back({exp_flow, (dly >= 1 && dly <= TIMEOUT) ? dat : 32'd0, exp_flow == exp_last});
      nstb++; exp_idx++;
      exp_flow = exp_flow + 10'd1;
    end
    if (poke && bus.out_valid) begin
      bus.rd_data_val = 1'b1;
      bus.rd_data     = '1;
    end
    start = 1'b0;
    if (start_req) begin
      start = 1'b1; first_flow = AW'(cur.first); last_flow = AW'(cur.last);
      start_cyc = cyc; start_req = 1'b0;
    end else if (poke && nstb > 0 && cyc == first_stb_cyc + 4) begin
      start = 1'b1; first_flow = 10'd500; last_flow = 10'd500;
    end else begin
      first_flow = '0; last_flow = '0;
    end
    if (bus.out_valid && ready_low_left > 0) begin
      bus.out_ready = 1'b0;
      ready_low_left--;
    end else begin
      bus.out_ready = 1'b1;
    end
    if (bus.out_valid) begin
      if (q.size() == 0) chk("beat_queue_nonempty", 64'(q.size()), 64'd1);
      else begin
        chk("beat", 64'({bus.out_flow, bus.out_data, bus.out_last}), 64'(q[0]));
        if (bus.out_ready) begin
          void'(q.pop_front());
          last_hs_cyc = cyc;
          nbeats++;
        end
      end
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
      chk("busy_in_done", 64'(busy), 64'd1);
    end
  endtask

  task automatic setup(input vec_t v);
    cur = v;
    exp_flow = AW'(v.first); exp_last = AW'(v.last);
    exp_idx = 0; nstb = 0; nbeats = 0; ndone = 0;
    ready_low_left = v.ready_low; poke = v.poke;
    pend = 1'b0; last_hs_cyc = -10; start_req = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    setup(v);
    for (int k = 0; k < 400 && ndone == 0; k++) tick();
    tick();
    chk("done_pulse_width", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_count", 64'(ndone), 64'd1);
    chk("strobe_count", 64'(nstb), 64'(v.exp_beats));
    chk("beat_count", 64'(nbeats), 64'(v.exp_beats));
    chk("stb_to_done_cycles", 64'(done_cyc - first_stb_cyc), 64'(v.exp_cycles));
    chk("total", 64'(total), 64'(v.exp_total));
    chk("max", 64'(max_v), 64'(v.exp_max));
    chk("max_flow", 64'(max_flow), 64'(v.exp_mf));
    chk("timeout_cnt", 64'(to_cnt), 64'(v.exp_to));
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_zero();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stb", 64'(bus.rd_stb), 64'd0);
    chk("rst_flow_num", 64'(bus.rd_flow_num), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_flow", 64'(bus.out_flow), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_total", 64'(total), 64'd0);
    chk("rst_max", 64'(max_v), 64'd0);
    chk("rst_max_flow", 64'(max_flow), 64'd0);
    chk("rst_timeout_cnt", 64'(to_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    //          first last  d0  d1  d2  d3 y0 y1 y2 y3 rlow poke tot  max mf   to beats cyc
    tbl[0] = mk(0,    3,    10, 20,  5, 20, 1, 1, 1, 1, 0,  0,   55,  20, 1,    0, 4,   12);
    tbl[1] = mk(2,    2,    77,  0,  0,  0, 1, 0, 0, 0, 5,  0,   77,  77, 2,    0, 1,    8);
    tbl[2] = mk(0,    2,     7, 99,  3,  0, 1, 0, 1, 0, 0,  0,   10,   7, 0,    1, 3,   24);
    tbl[3] = mk(4,    4,   123,  0,  0,  0,16, 0, 0, 0, 0,  0,  123, 123, 4,    0, 1,   18);
    tbl[4] = mk(1022, 1,     5,  9,  9,  2, 1, 2, 1, 1, 0,  1,   25,   9, 1023, 0, 4,   13);
    tbl[5] = mk(7,    8,    50, 60,  0,  0, 0,17, 0, 0, 0,  0,    0,   0, 0,    2, 2,   36);
    tbl[6] = mk(5,    5,    42,  0,  0,  0, 1, 0, 0, 0, 0,  0,   42,  42, 5,    0, 1,    3);

    rst_n = 1'b0; start = 1'b0; first_flow = '0; last_flow = '0;
    bus.rd_data = '0; bus.rd_data_val = 1'b0; bus.out_ready = 1'b1;
    setup(tbl[0]); start_req = 1'b0;
    tick(); tick();
    check_zero();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Reset while flow 2 of a 0..3 sweep is waiting on a response that never comes.
    setup(mk(0, 3, 1, 2, 3, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0));
    for (int k = 0; k < 100 && nstb < 3; k++) tick();
    repeat (3) tick();
    chk("pre_reset_total", 64'(total), 64'd3);
    #2 rst_n = 1'b0;
    #1 check_zero();
    q.delete(); pend = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_vec(tbl[6]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
